// File: rtl/olivia_boot_loader_if.sv
// Byte-stream and instruction-memory write bus of the Olivia boot loader.
// master = the loader itself, slave = byte source plus instruction memory.
interface olivia_boot_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/olivia_boot_loader.sv
// Boot loader: byte stream -> little-endian words -> imem writes, holds the core until done.
// Optional trailing XOR checksum byte enabled by BOOT_LOADER_CHECKSUM_EN.
module olivia_boot_loader #(
    parameter int IMEM_DEPTH_WORDS = 64,
    parameter int CNT_W            = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    olivia_boot_loader_if.master bus,
    output logic                 core_hold,
    output logic                 done,
    output logic                 error
);
    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
`ifdef BOOT_LOADER_CHECKSUM_EN
        CHECK,
`endif
        RUN,
        ERR
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             imem_we_q;
    logic [63:0]      imem_addr_q;
    logic [31:0]      imem_wdata_q;
    logic             core_hold_q;
    logic             done_q;
    logic             error_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] word_idx_q;
    logic [1:0]       byte_idx_q;
    logic [23:0]      byte_buf_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]       chk_q;
`endif

    logic             accept;
    logic [CNT_W-1:0] count_d;
    logic [31:0]      word_d;
    logic             last_word;

    assign accept    = bus.in_valid && in_ready_q;
    assign count_d   = CNT_W'({bus.in_data, count_q[7:0]});
    assign word_d    = {bus.in_data, byte_buf_q};
    assign last_word = (word_idx_q == count_q - CNT_W'(1));

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign core_hold      = core_hold_q;
    assign done           = done_q;
    assign error          = error_q;

    // NOTE: every register here updates with <= so all of them sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= LEN_LO;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_hold_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            count_q      <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            byte_buf_q   <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            // NOTE: the write strobe is a single-cycle pulse, so it defaults low every cycle.
            imem_we_q <= 1'b0;
            case (state_q)
                LEN_LO: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        count_q[7:0] <= bus.in_data;
                        state_q      <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        count_q <= count_d;
                        if (count_d > CNT_W'(IMEM_DEPTH_WORDS)) begin
                            state_q    <= ERR;
                            in_ready_q <= 1'b0;
                        end else if (count_d == '0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                            state_q    <= CHECK;
`else
                            state_q    <= RUN;
                            in_ready_q <= 1'b0;
`endif
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        chk_q <= chk_q ^ bus.in_data;
`endif
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: byte_buf_q[7:0]   <= bus.in_data;
                            2'd1: byte_buf_q[15:8]  <= bus.in_data;
                            2'd2: byte_buf_q[23:16] <= bus.in_data;
                            default: begin
                                // Word is registered here, so the stream never stalls for the write.
                                imem_we_q    <= 1'b1;
                                imem_addr_q  <= 64'(word_idx_q) << 2;
                                imem_wdata_q <= word_d;
                                word_idx_q   <= word_idx_q + CNT_W'(1);
                                if (last_word) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                                    state_q    <= CHECK;
`else
                                    state_q    <= RUN;
                                    in_ready_q <= 1'b0;
`endif
                                end
                            end
                        endcase
                    end
                end
`ifdef BOOT_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        state_q    <= (bus.in_data == chk_q) ? RUN : ERR;
                    end
                end
`endif
                RUN: begin
                    core_hold_q <= 1'b0;
                    done_q      <= 1'b1;
                end
                ERR: begin
                    error_q <= 1'b1;
                end
                default: begin
                    state_q    <= ERR;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_olivia_boot_loader.sv
// Self-checking bench for olivia_boot_loader: vector table of randomized images,
// a byte-level reference model, and hand-written mid-load reset / fixed-image sequences.
module tb_olivia_boot_loader;
    localparam int DEPTH = 64;
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic core_hold, done, error;
    int   tests = 0;
    int   fails = 0;

    olivia_boot_loader_if bus ();

    olivia_boot_loader #(
        .IMEM_DEPTH_WORDS(DEPTH),
        .CNT_W           (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .core_hold(core_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    logic [63:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_words[$];
    logic [7:0]  img[$];

    // Record every write; the core must still be held whenever a write is in flight.
    always @(negedge clk) begin
        if (rst && bus.imem_we) begin
            got_addr.push_back(bus.imem_addr);
            got_data.push_back(bus.imem_wdata);
            tests++;
            if (core_hold !== 1'b1) begin
                fails++;
                $display("FAIL hold_during_write: core_hold=%0b required 1", core_hold);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        got_addr.delete();
        got_data.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_byte(input logic [7:0] b, input bit rnd, output bit ok);
        int n;
        if (rnd) begin
            while ($urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = bus.in_ready;
        if (ok) begin
            @(negedge clk);
        end else begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: in_ready=0 required 1 within 40 cycles");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_checks(input string name, input bit exp_done, input bit exp_error);
        int n;
        n = 0;
        while (!(done || error) && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check({name, "_done"},      64'(done),      64'(exp_done));
        check({name, "_error"},     64'(error),     64'(exp_error));
        check({name, "_core_hold"}, 64'(core_hold), 64'(!exp_done));
        check({name, "_in_ready"},  64'(bus.in_ready), 64'd0);
        check({name, "_nwrites"},   64'(got_addr.size()), 64'(exp_words.size()));
        for (int i = 0; i < exp_words.size() && i < got_addr.size(); i++) begin
            check({name, "_addr"}, got_addr[i], 64'(i) * 64'd4);
            check({name, "_data"}, 64'(got_data[i]), 64'(exp_words[i]));
        end
    endtask

    // Reference: words are bytes weighted by 256^k, checksum is the XOR of all data bytes.
    task automatic load_image(input string name, input logic [15:0] count, input logic [7:0] delta,
                              input bit rnd, input bit exp_done, input bit exp_error);
        logic [7:0] chk;
        bit         ok;
        chk = 8'h00;
        exp_words.delete();
        for (int i = 0; i < img.size(); i++) chk ^= img[i];
        for (int w = 0; w < img.size() / 4; w++) begin
            exp_words.push_back(32'(img[4*w]) + (32'(img[4*w+1]) * 32'd256)
                              + (32'(img[4*w+2]) * 32'd65536) + (32'(img[4*w+3]) * 32'd16777216));
        end
        send_byte(count[7:0], rnd, ok);
        if (ok) send_byte(count[15:8], rnd, ok);
        for (int i = 0; i < img.size() && ok; i++) send_byte(img[i], rnd, ok);
        if (ok && CK) send_byte(chk ^ delta, rnd, ok);
        finish_checks(name, exp_done, exp_error);
    endtask

    typedef struct {
        logic [15:0] count;
        logic [7:0]  delta;
        bit          rnd;
        bit          exp_done;
        bit          exp_error;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'd1,      8'h00, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{16'd3,      8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'd64,     8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{16'd5,      8'h40, 1'b0, !CK,  CK};
        vecs[4] = '{16'd65,     8'h00, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h0100,   8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'd0,      8'h00, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{16'd0,      8'h01, 1'b0, !CK,  CK};
        vecs[8] = '{16'd7,      8'h00, 1'b1, 1'b1, 1'b0};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b0;
        #12;
        check("rst_in_ready",   64'(bus.in_ready),   64'd0);
        check("rst_imem_we",    64'(bus.imem_we),    64'd0);
        check("rst_imem_addr",  bus.imem_addr,       64'd0);
        check("rst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
        check("rst_core_hold",  64'(core_hold),      64'd1);
        check("rst_done",       64'(done),           64'd0);
        check("rst_error",      64'(error),          64'd0);
        @(negedge clk);

        // Fixed two-word image; its data bytes XOR to 0xA8, the second pass sends 0x94.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            img = '{8'h13, 8'h00, 8'h80, 8'hD2, 8'h1F, 8'h20, 8'h03, 8'hD5};
            load_image(pass == 0 ? "fixed_good" : "fixed_badchk", 16'd2,
                       pass == 0 ? 8'h00 : 8'h3C, 1'b0, pass == 0 || !CK, pass == 1 && CK);
            check("fixed_word0", 64'(exp_words[0]), 64'hD280_0013);
            check("fixed_word1", 64'(exp_words[1]), 64'hD503_201F);
        end

        foreach (vecs[v]) begin
            do_reset();
            img.delete();
            if (vecs[v].count <= 16'(DEPTH)) begin
                for (int i = 0; i < int'(vecs[v].count) * 4; i++) img.push_back(8'($urandom));
            end
            load_image($sformatf("vec%0d", v), vecs[v].count, vecs[v].delta, vecs[v].rnd,
                       vecs[v].exp_done, vecs[v].exp_error);
        end

        // Reset in the middle of a three-word load, then a fresh one-word load.
        begin
            bit ok;
            logic [7:0] part[6];
            do_reset();
            part = '{8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
            ok = 1'b1;
            for (int i = 0; i < 6 && ok; i++) send_byte(part[i], 1'b0, ok);
            #2;
            rst = 1'b0;
            #1;
            check("abort_in_ready",   64'(bus.in_ready),   64'd0);
            check("abort_imem_we",    64'(bus.imem_we),    64'd0);
            check("abort_imem_addr",  bus.imem_addr,       64'd0);
            check("abort_imem_wdata", 64'(bus.imem_wdata), 64'd0);
            check("abort_core_hold",  64'(core_hold),      64'd1);
            check("abort_done",       64'(done),           64'd0);
            check("abort_error",      64'(error),          64'd0);
            @(negedge clk);
            rst = 1'b1;
            got_addr.delete();
            got_data.delete();
            img = '{8'h37, 8'h05, 8'h00, 8'h00};
            load_image("after_abort", 16'd1, 8'h00, 1'b0, 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
